// File: rtl/gpio_debounce_in.sv
// Debounced GPIO input block with edge flags, interrupt enables and a simple register bus.
// Level latency FREQ+2 cycles from pin change; bus accesses ack one cycle later, never stall.
module gpio_debounce_in #(
   parameter int WIDTH = 6,
   parameter int FREQ  = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] pin_i,
   input  logic             req_i,
   input  logic             we_i,
   input  logic [1:0]       addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o,
   output logic             ack_o,
   output logic [WIDTH-1:0] level_o,
   output logic             irq_o
);
   localparam int CW = $clog2(FREQ + 1);
   localparam logic [CW-1:0] LIMIT = CW'(FREQ - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_level;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic [WIDTH-1:0] r_ien_r;
   logic [WIDTH-1:0] r_ien_f;
   logic [CW-1:0]    r_cnt [WIDTH];
   logic             r_ack;
   logic [31:0]      r_rdata;

   logic [WIDTH-1:0] w_toggle;
   logic [WIDTH-1:0] w_rise_set;
   logic [WIDTH-1:0] w_fall_set;
   logic [WIDTH-1:0] w_rise_clr;
   logic [WIDTH-1:0] w_fall_clr;
   logic             w_wr;
   logic [31:0]      w_rd;
   logic             w_unused_wdata;

   // A bit flips on the edge where its mismatch counter would reach FREQ.
   always_comb begin
      w_toggle = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_toggle[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == LIMIT);
      end
   end

   assign w_rise_set = w_toggle & ~r_level;
   assign w_fall_set = w_toggle & r_level;
   assign w_wr       = req_i & we_i;
   assign w_rise_clr = (w_wr && addr_i == 2'd1) ? wdata_i[WIDTH-1:0] : '0;
   assign w_fall_clr = (w_wr && addr_i == 2'd2) ? wdata_i[WIDTH-1:0] : '0;
   assign w_unused_wdata = ^wdata_i;

   always_comb begin
      w_rd = 32'd0;
      case (addr_i)
         2'd0:    w_rd = 32'(r_level);
         2'd1:    w_rd = 32'(r_rise);
         2'd2:    w_rd = 32'(r_fall);
         default: w_rd = {16'(r_ien_f), 16'(r_ien_r)};
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_level <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
         r_ien_r <= '0;
         r_ien_f <= '0;
         r_ack   <= 1'b0;
         r_rdata <= 32'd0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= pin_i;
         r_sync2 <= r_sync1;
         r_level <= r_level ^ w_toggle;
         for (int i = 0; i < WIDTH; i++) begin
            if ((r_sync2[i] == r_level[i]) || w_toggle[i]) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
         // A new edge beats a simultaneous W1C clear of the same flag.
         r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
         r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
         if (w_wr && addr_i == 2'd3) begin
            r_ien_r <= wdata_i[WIDTH-1:0];
            r_ien_f <= wdata_i[16 +: WIDTH];
         end
         r_ack   <= req_i;
         r_rdata <= req_i ? w_rd : 32'd0;
      end
   end

   assign rdata_o = r_rdata;
   assign ack_o   = r_ack;
   assign level_o = r_level;
   assign irq_o   = |((r_rise & r_ien_r) | (r_fall & r_ien_f));

endmodule

// File: tb/tb_gpio_debounce_in.sv
// Bench for gpio_debounce_in: window-based reference model checked every cycle plus directed literals.
module tb_gpio_debounce_in;
   localparam int WIDTH = 6;
   localparam int FREQ  = 10;

   logic             clk = 1'b0;
   logic             rst_i;
   logic [WIDTH-1:0] pin_i;
   logic             req_i;
   logic             we_i;
   logic [1:0]       addr_i;
   logic [31:0]      wdata_i;
   logic [31:0]      rdata_o;
   logic             ack_o;
   logic [WIDTH-1:0] level_o;
   logic             irq_o;

   always #5 clk = ~clk;

   gpio_debounce_in #(.WIDTH(WIDTH), .FREQ(FREQ)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .pin_i   (pin_i),
      .req_i   (req_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .ack_o   (ack_o),
      .level_o (level_o),
      .irq_o   (irq_o)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   // Reference: a bit flips when the last FREQ synchronized samples
   // (pin samples two edges old and older) all disagree with the level.
   logic [WIDTH-1:0] m_lvl, m_rise, m_fall, m_ien_r, m_ien_f;
   logic [WIDTH-1:0] m_hist [0:FREQ];
   logic             m_ack;
   logic [31:0]      m_rdata;
   bit               m_valid = 1'b0;

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_lvl);
         2'd1:    return 32'(m_rise);
         2'd2:    return 32'(m_fall);
         default: return {16'(m_ien_f), 16'(m_ien_r)};
      endcase
   endfunction

   always @(posedge clk) begin : model
      logic [WIDTH-1:0] tog, clr_r, clr_f;
      logic [31:0]      rd;
      if (rst_i) begin
         m_lvl = '0; m_rise = '0; m_fall = '0; m_ien_r = '0; m_ien_f = '0;
         m_ack = 1'b0; m_rdata = 32'd0;
         for (int j = 0; j <= FREQ; j++) m_hist[j] = '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            tog[i] = 1'b1;
            for (int j = 1; j <= FREQ; j++)
               if (m_hist[j][i] == m_lvl[i]) tog[i] = 1'b0;
         end
         rd      = m_read(addr_i);
         m_ack   = req_i;
         m_rdata = req_i ? rd : 32'd0;
         clr_r = (req_i && we_i && addr_i == 2'd1) ? wdata_i[WIDTH-1:0] : '0;
         clr_f = (req_i && we_i && addr_i == 2'd2) ? wdata_i[WIDTH-1:0] : '0;
         if (req_i && we_i && addr_i == 2'd3) begin
            m_ien_r = wdata_i[WIDTH-1:0];
            m_ien_f = wdata_i[16 +: WIDTH];
         end
         m_rise = (m_rise & ~clr_r) | (tog & ~m_lvl);
         m_fall = (m_fall & ~clr_f) | (tog & m_lvl);
         m_lvl  = m_lvl ^ tog;
         for (int j = FREQ; j >= 1; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = pin_i;
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("level_o", 32'(level_o), 32'(m_lvl));
         check("irq_o", 32'(irq_o), 32'(|((m_rise & m_ien_r) | (m_fall & m_ien_f))));
         check("ack_o", 32'(ack_o), 32'(m_ack));
         check("rdata_o", rdata_o, m_rdata);
      end
   end

   task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
      @(negedge clk);
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
      @(negedge clk);
      req_i = 1'b0; we_i = 1'b0;
      rd = rdata_o;
   endtask

   logic [31:0] rd;

   initial begin
      rst_i = 1'b1; pin_i = '0; req_i = 1'b0; we_i = 1'b0; addr_i = 2'd0; wdata_i = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_level", 32'(level_o), 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_ack", 32'(ack_o), 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      rst_i = 1'b0;
      for (int a = 0; a < 4; a++) begin
         bus(1'b0, 2'(a), 32'd0, rd);
         check("rst_reg", rd, 32'd0);
      end

      // Held rise on pin 0: level flips 12 edges after the change.
      @(negedge clk); pin_i[0] = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk); check("rise_lat11", 32'(level_o), 32'h0);
      @(negedge clk); check("rise_lat12", 32'(level_o), 32'h1);
      bus(1'b0, 2'd1, 32'd0, rd); check("rise_rd", rd, 32'h1);
      bus(1'b0, 2'd2, 32'd0, rd); check("fall_rd0", rd, 32'h0);
      bus(1'b1, 2'd1, 32'h1, rd);

      // Short glitch on pin 3 is swallowed.
      @(negedge clk); pin_i[3] = 1'b1;
      repeat (5) @(negedge clk); pin_i[3] = 1'b0;
      repeat (30) @(negedge clk);
      check("glitch_lvl", 32'(level_o), 32'h1);
      bus(1'b0, 2'd1, 32'd0, rd); check("glitch_rise", rd, 32'h0);
      bus(1'b0, 2'd2, 32'd0, rd); check("glitch_fall", rd, 32'h0);

      // Rise interrupt on pin 0 and its W1C clear.
      bus(1'b1, 2'd3, 32'h0000_0001, rd);
      @(negedge clk); pin_i[0] = 1'b0;
      repeat (13) @(negedge clk);
      check("fall_lvl", 32'(level_o), 32'h0);
      check("fall_noirq", 32'(irq_o), 32'd0);
      bus(1'b0, 2'd2, 32'd0, rd); check("fall_rd1", rd, 32'h1);
      bus(1'b1, 2'd2, 32'h1, rd);
      @(negedge clk); pin_i[0] = 1'b1;
      repeat (13) @(negedge clk);
      check("irq_set", 32'(irq_o), 32'd1);
      bus(1'b1, 2'd1, 32'h1, rd);
      check("irq_clr", 32'(irq_o), 32'd0);
      bus(1'b0, 2'd1, 32'd0, rd); check("rise_cleared", rd, 32'h0);

      // Clear of RISE[1] lands on the very edge that sets it.
      @(negedge clk); pin_i[1] = 1'b1;
      repeat (11) @(posedge clk);
      bus(1'b1, 2'd1, 32'h2, rd);
      check("setwins_lvl", 32'(level_o), 32'h3);
      bus(1'b0, 2'd1, 32'd0, rd); check("setwins_rise", rd, 32'h2);

      // Back-to-back write IEN, read IEN, read LEVEL.
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; addr_i = 2'd3; wdata_i = 32'h0003_0003;
      @(negedge clk); check("b2b_ack0", 32'(ack_o), 32'd1);
      we_i = 1'b0; addr_i = 2'd3;
      @(negedge clk); check("b2b_ack1", 32'(ack_o), 32'd1);
      check("b2b_ien", rdata_o, 32'h0003_0003);
      addr_i = 2'd0;
      @(negedge clk); check("b2b_ack2", 32'(ack_o), 32'd1);
      check("b2b_level", rdata_o, 32'h3);
      req_i = 1'b0;
      @(negedge clk); check("b2b_idle", 32'(ack_o), 32'd0);
      check("b2b_irq", 32'(irq_o), 32'd1);

      // Reset during an access, with pins held high across release.
      @(negedge clk);
      pin_i = 6'h21; req_i = 1'b1; we_i = 1'b0; addr_i = 2'd1; rst_i = 1'b1;
      @(negedge clk); req_i = 1'b0;
      check("abort_ack", 32'(ack_o), 32'd0);
      check("abort_lvl", 32'(level_o), 32'd0);
      check("abort_irq", 32'(irq_o), 32'd0);
      @(negedge clk); rst_i = 1'b0;
      repeat (11) @(negedge clk); check("rel_lat11", 32'(level_o), 32'h0);
      @(negedge clk); check("rel_lat12", 32'(level_o), 32'h21);
      bus(1'b0, 2'd1, 32'd0, rd); check("rel_rise", rd, 32'h21);
      @(negedge clk); pin_i = '0;
      repeat (13) @(negedge clk);
      bus(1'b0, 2'd2, 32'd0, rd); check("rel_fall", rd, 32'h21);
      bus(1'b0, 2'd3, 32'd0, rd); check("rel_ien", rd, 32'h0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
